// File: rtl/traffic_phase_monitor_pkg.sv
// Shared lamp encodings, phase states, fault codes and direction indices for the
// traffic phase monitor.
package traffic_phase_monitor_pkg;

    localparam logic [2:0] LT_RED = 3'b100;
    localparam logic [2:0] LT_YEL = 3'b010;
    localparam logic [2:0] LT_GRN = 3'b001;

    typedef enum logic [2:0] {
        PH_GRN = LT_GRN,
        PH_YEL = LT_YEL,
        PH_RED = LT_RED
    } phase_e;

    localparam logic [2:0] FC_NONE         = 3'd0;
    localparam logic [2:0] FC_CONFLICT     = 3'd1;
    localparam logic [2:0] FC_BAD_ENC      = 3'd2;
    localparam logic [2:0] FC_ILLEGAL      = 3'd3;
    localparam logic [2:0] FC_SHORT_GREEN  = 3'd4;
    localparam logic [2:0] FC_SHORT_YELLOW = 3'd5;
    localparam logic [2:0] FC_LONG_YELLOW  = 3'd6;
    localparam logic [2:0] FC_STALL        = 3'd7;

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    // Bit 0 is N, so the lowest set bit gives the N>E>S>W tie-break.
    function automatic logic [1:0] first_dir(input logic [3:0] v);
        if (v[0])      return DIR_N;
        else if (v[1]) return DIR_E;
        else if (v[2]) return DIR_S;
        else           return DIR_W;
    endfunction

endpackage

// File: rtl/traffic_phase_monitor_if.sv
// Bundle of the observed lamp signals and the monitor's fault/status outputs.
// master = controller/observer side, slave = monitor side.
interface traffic_phase_monitor_if;
    logic [2:0]  light_N;
    logic [2:0]  light_E;
    logic [2:0]  light_S;
    logic [2:0]  light_W;
    logic [3:0]  wait_time;
    logic        fault_clr;
    logic        fault;
    logic [2:0]  fault_code;
    logic [1:0]  fault_dir;
    logic [3:0]  fault_wait;
    logic [15:0] rotations;
    logic        phase_pulse;

    modport master (
        output light_N, light_E, light_S, light_W, wait_time, fault_clr,
        input  fault, fault_code, fault_dir, fault_wait, rotations, phase_pulse
    );

    modport slave (
        input  light_N, light_E, light_S, light_W, wait_time, fault_clr,
        output fault, fault_code, fault_dir, fault_wait, rotations, phase_pulse
    );
endinterface

// File: rtl/traffic_phase_monitor_tracker.sv
// Per-approach phase tracker: follows RED->GREEN->YELLOW->RED, keeps a saturating
// dwell counter and flags encoding, transition and dwell violations on the current sample.
module light_dir_tracker
    import traffic_phase_monitor_pkg::*;
#(
    parameter int MIN_GREEN  = 2,
    parameter int MIN_YELLOW = 1,
    parameter int MAX_YELLOW = 4,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] i_light,
    input  logic       i_base,
    input  logic       i_chk,
    output phase_e     o_phase,
    output logic       o_bad_enc,
    output logic       o_illegal,
    output logic       o_short_green,
    output logic       o_short_yel,
    output logic       o_long_yel,
    output logic       o_phase_chg
);

    phase_e             r_phase;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_first;
    phase_e             w_cur;
    logic               w_bad;
    logic [CNT_W-1:0]   w_cnt_inc;

    assign w_bad     = (i_base || i_chk) && !$onehot(i_light);
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    assign o_phase   = r_phase;
    assign o_bad_enc = w_bad;

    always_comb begin
        case (i_light)
            LT_GRN:  w_cur = PH_GRN;
            LT_YEL:  w_cur = PH_YEL;
            default: w_cur = PH_RED;
        endcase
    end

    // Checks compare the stored phase (previous sample) with the current sample.
    always_comb begin
        o_illegal     = 1'b0;
        o_short_green = 1'b0;
        o_short_yel   = 1'b0;
        o_long_yel    = 1'b0;
        o_phase_chg   = 1'b0;
        if (i_chk && !w_bad) begin
            o_phase_chg = (w_cur != r_phase);
            case (r_phase)
                PH_RED: o_illegal = (w_cur == PH_YEL);
                PH_GRN: begin
                    o_illegal     = (w_cur == PH_RED);
                    o_short_green = (w_cur == PH_YEL) && !r_first && (r_cnt < CNT_W'(MIN_GREEN));
                end
                PH_YEL: begin
                    o_illegal   = (w_cur == PH_GRN);
                    o_short_yel = (w_cur == PH_RED) && !r_first && (r_cnt < CNT_W'(MIN_YELLOW));
                    o_long_yel  = (w_cur == PH_YEL) && (w_cnt_inc == CNT_W'(MAX_YELLOW + 1));
                end
                default: o_illegal = 1'b1;
            endcase
        end
    end

    // A badly encoded sample leaves phase and dwell untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= PH_RED;
            r_cnt   <= '0;
            r_first <= 1'b1;
        end else if (i_base && !w_bad) begin
            r_phase <= w_cur;
            r_cnt   <= CNT_W'(1);
            r_first <= 1'b1;
        end else if (i_chk && !w_bad) begin
            if (w_cur != r_phase) begin
                r_phase <= w_cur;
                r_cnt   <= CNT_W'(1);
                r_first <= 1'b0;
            end else begin
                r_cnt   <= w_cnt_inc;
            end
        end
    end

endmodule

// File: rtl/traffic_phase_monitor.sv
// Passive safety monitor on the traffic light outputs: registers the lamps, runs one
// tracker per approach, and latches the first (highest priority) rule violation.
module traffic_phase_monitor
    import traffic_phase_monitor_pkg::*;
#(
    parameter int MIN_GREEN   = 2,
    parameter int MIN_YELLOW  = 1,
    parameter int MAX_YELLOW  = 4,
    parameter int MAX_ALL_RED = 8,
    parameter int CNT_W       = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    traffic_phase_monitor_if.slave  mon
);

    logic [2:0]        r_light_p0 [4];
    logic [3:0]        r_wait_p0;
    logic              r_vld_p0;
    logic              r_smp_vld;
    logic [CNT_W-1:0]  r_allred_cnt;
    logic              r_fault;
    logic [2:0]        r_code;
    logic [1:0]        r_dir;
    logic [3:0]        r_fwait;
    logic [15:0]       r_rot;
    logic              r_pulse;

    logic              w_base, w_chk;
    phase_e            w_phase [4];
    logic [3:0]        w_bad, w_ill, w_sg, w_sy, w_ly, w_chg, w_nonred;
    logic              w_conflict, w_allred, w_stall, w_rot;
    logic [CNT_W-1:0]  w_allred_inc;
    logic [2:0]        w_code;
    logic [1:0]        w_dir;

    // Stage p0: sample the lamps and wait_time.
    always_ff @(posedge clk) begin
        r_light_p0[DIR_N] <= mon.light_N;
        r_light_p0[DIR_E] <= mon.light_E;
        r_light_p0[DIR_S] <= mon.light_S;
        r_light_p0[DIR_W] <= mon.light_W;
        r_wait_p0         <= mon.wait_time;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p0  <= 1'b0;
            r_smp_vld <= 1'b0;
        end else begin
            r_vld_p0  <= 1'b1;
            r_smp_vld <= r_smp_vld | r_vld_p0;
        end
    end

    assign w_base = r_vld_p0 && !r_smp_vld;
    assign w_chk  = r_vld_p0 && r_smp_vld;

    for (genvar g = 0; g < 4; g++) begin : g_trk
        light_dir_tracker #(
            .MIN_GREEN (MIN_GREEN),
            .MIN_YELLOW(MIN_YELLOW),
            .MAX_YELLOW(MAX_YELLOW),
            .CNT_W     (CNT_W)
        ) u_trk (
            .clk          (clk),
            .rst          (rst),
            .i_light      (r_light_p0[g]),
            .i_base       (w_base),
            .i_chk        (w_chk),
            .o_phase      (w_phase[g]),
            .o_bad_enc    (w_bad[g]),
            .o_illegal    (w_ill[g]),
            .o_short_green(w_sg[g]),
            .o_short_yel  (w_sy[g]),
            .o_long_yel   (w_ly[g]),
            .o_phase_chg  (w_chg[g])
        );
        assign w_nonred[g] = (r_light_p0[g] != LT_RED);
    end

    assign w_conflict   = r_vld_p0 && !$onehot0(w_nonred);
    assign w_allred     = r_vld_p0 && (w_nonred == 4'b0000);
    assign w_allred_inc = (r_allred_cnt == '1) ? r_allred_cnt : r_allred_cnt + 1'b1;
    assign w_stall      = w_allred && (w_allred_inc == CNT_W'(MAX_ALL_RED + 1));
    assign w_rot        = w_chg[DIR_W] && (w_phase[DIR_W] == PH_YEL) && (r_light_p0[DIR_W] == LT_RED);

    always_comb begin
        w_code = FC_NONE;
        w_dir  = DIR_N;
        if (w_conflict) begin
            w_code = FC_CONFLICT;
        end else if (|w_bad) begin
            w_code = FC_BAD_ENC;
            w_dir  = first_dir(w_bad);
        end else if (|w_ill) begin
            w_code = FC_ILLEGAL;
            w_dir  = first_dir(w_ill);
        end else if (|w_sg) begin
            w_code = FC_SHORT_GREEN;
            w_dir  = first_dir(w_sg);
        end else if (|w_sy) begin
            w_code = FC_SHORT_YELLOW;
            w_dir  = first_dir(w_sy);
        end else if (|w_ly) begin
            w_code = FC_LONG_YELLOW;
            w_dir  = first_dir(w_ly);
        end else if (w_stall) begin
            w_code = FC_STALL;
        end
    end

    // Stage p1: fault latch and status counters. A new violation wins over fault_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_allred_cnt <= '0;
            r_fault      <= 1'b0;
            r_code       <= FC_NONE;
            r_dir        <= DIR_N;
            r_fwait      <= 4'd0;
            r_rot        <= 16'd0;
            r_pulse      <= 1'b0;
        end else begin
            if (r_vld_p0)
                r_allred_cnt <= w_allred ? w_allred_inc : '0;
            if ((w_code != FC_NONE) && (!r_fault || mon.fault_clr)) begin
                r_fault <= 1'b1;
                r_code  <= w_code;
                r_dir   <= w_dir;
                r_fwait <= r_wait_p0;
            end else if (mon.fault_clr) begin
                r_fault <= 1'b0;
                r_code  <= FC_NONE;
                r_dir   <= DIR_N;
                r_fwait <= 4'd0;
            end
            if (w_rot)
                r_rot <= r_rot + 16'd1;
            r_pulse <= |w_chg;
        end
    end

    assign mon.fault       = r_fault;
    assign mon.fault_code  = r_code;
    assign mon.fault_dir   = r_dir;
    assign mon.fault_wait  = r_fwait;
    assign mon.rotations   = r_rot;
    assign mon.phase_pulse = r_pulse;

endmodule

// File: tb/tb_traffic_phase_monitor.sv
// Table-driven bench for traffic_phase_monitor: each row drives one cycle of inputs and
// checks the outputs just after that cycle's rising edge.
module tb_traffic_phase_monitor;

    localparam logic [2:0] R  = 3'b100;
    localparam logic [2:0] Y  = 3'b010;
    localparam logic [2:0] G  = 3'b001;
    localparam logic [2:0] BD = 3'b011;

    typedef struct {
        logic        rst;
        logic [2:0]  n, e, s, w;
        logic [3:0]  wt;
        logic        clr;
        logic        f;
        logic [2:0]  c;
        logic [1:0]  d;
        logic [3:0]  fw;
        logic [15:0] rot;
        logic        p;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    traffic_phase_monitor_if mon_if ();

    traffic_phase_monitor dut (
        .clk(clk),
        .rst(rst),
        .mon(mon_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r_, input logic [2:0] n_, input logic [2:0] e_,
                                input logic [2:0] s_, input logic [2:0] w_, input logic [3:0] wt_,
                                input logic clr_, input logic f_, input logic [2:0] c_,
                                input logic [1:0] d_, input logic [3:0] fw_,
                                input logic [15:0] rot_, input logic p_);
        vec_t v;
        v.rst = r_; v.n = n_; v.e = e_; v.s = s_; v.w = w_; v.wt = wt_; v.clr = clr_;
        v.f = f_; v.c = c_; v.d = d_; v.fw = fw_; v.rot = rot_; v.p = p_;
        return v;
    endfunction

    task automatic step(input vec_t v, input string name);
        logic [26:0] got;
        logic [26:0] exp;
        rst              = v.rst;
        mon_if.light_N   = v.n;
        mon_if.light_E   = v.e;
        mon_if.light_S   = v.s;
        mon_if.light_W   = v.w;
        mon_if.wait_time = v.wt;
        mon_if.fault_clr = v.clr;
        @(posedge clk);
        #1;
        got = {mon_if.fault, mon_if.fault_code, mon_if.fault_dir, mon_if.fault_wait,
               mon_if.rotations, mon_if.phase_pulse};
        exp = {v.f, v.c, v.d, v.fw, v.rot, v.p};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got fault=%0b code=%0d dir=%0d wait=%0d rot=%0d pulse=%0b, want fault=%0b code=%0d dir=%0d wait=%0d rot=%0d pulse=%0b",
                     name, mon_if.fault, mon_if.fault_code, mon_if.fault_dir, mon_if.fault_wait,
                     mon_if.rotations, mon_if.phase_pulse, v.f, v.c, v.d, v.fw, v.rot, v.p);
        end
    endtask

    vec_t tbl[$];

    initial begin
        checks   = 0;
        failures = 0;

        // Reset, then a legal N,E,S,W rotation (G3/Y2) ending with W yellow->red.
        tbl.push_back(mk(1, R,R,R,R, 0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(1, R,R,R,R, 0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0, R,R,R,R, 0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0, G,R,R,R, 0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0, G,R,R,R, 0,0, 0,0,0,0, 0,1));
        tbl.push_back(mk(0, G,R,R,R, 0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0, Y,R,R,R, 0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0, Y,R,R,R, 0,0, 0,0,0,0, 0,1));
        tbl.push_back(mk(0, R,G,R,R, 0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0, R,G,R,R, 0,0, 0,0,0,0, 0,1));
        tbl.push_back(mk(0, R,G,R,R, 0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0, R,Y,R,R, 0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0, R,Y,R,R, 0,0, 0,0,0,0, 0,1));
        tbl.push_back(mk(0, R,R,G,R, 0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0, R,R,G,R, 0,0, 0,0,0,0, 0,1));
        tbl.push_back(mk(0, R,R,G,R, 0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0, R,R,Y,R, 0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0, R,R,Y,R, 0,0, 0,0,0,0, 0,1));
        tbl.push_back(mk(0, R,R,R,G, 0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0, R,R,R,G, 0,0, 0,0,0,0, 0,1));
        tbl.push_back(mk(0, R,R,R,G, 0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0, R,R,R,Y, 0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0, R,R,R,Y, 0,0, 0,0,0,0, 0,1));
        tbl.push_back(mk(0, R,R,R,R, 0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0, R,R,R,R, 0,0, 0,0,0,0, 1,1));
        tbl.push_back(mk(0, R,R,R,R, 0,0, 0,0,0,0, 1,0));
        // N and E green together: conflict two edges later.
        tbl.push_back(mk(0, G,G,R,R, 0,0, 0,0,0,0, 1,0));
        tbl.push_back(mk(0, R,R,R,R, 0,0, 1,1,0,0, 1,1));
        tbl.push_back(mk(1, R,R,R,R, 0,0, 0,0,0,0, 0,0));
        // N green->red and E red->yellow in one sample: N wins the tie.
        tbl.push_back(mk(0, G,R,R,R, 0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0, G,R,R,R, 0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0, R,Y,R,R, 0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0, R,R,R,R, 0,0, 1,3,0,0, 0,1));
        tbl.push_back(mk(1, R,R,R,R, 0,0, 0,0,0,0, 0,0));
        // S yellow for five samples: long yellow, wait_time of the fifth sample captured.
        tbl.push_back(mk(0, R,R,Y,R, 1,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0, R,R,Y,R, 2,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0, R,R,Y,R, 3,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0, R,R,Y,R, 4,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0, R,R,Y,R, 5,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0, R,R,R,R, 6,0, 1,6,2,5, 0,0));
        tbl.push_back(mk(0, R,R,R,R, 0,0, 1,6,2,5, 0,1));
        tbl.push_back(mk(1, R,R,R,R, 0,0, 0,0,0,0, 0,0));
        // Bad encoding on E, then fault_clr while legal.
        tbl.push_back(mk(0, R,R,R,R, 0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0, R,R,R,R, 0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0, R,BD,R,R, 9,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0, R,R,R,R, 0,0, 1,2,1,9, 0,0));
        tbl.push_back(mk(0, R,R,R,R, 0,1, 0,0,0,0, 0,0));
        // All-red run: the ninth consecutive all-red sample stalls, fault_clr does not block it.
        for (int i = 0; i < 6; i++)
            tbl.push_back(mk(0, R,R,R,R, 0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0, R,R,R,R, 7,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0, R,R,R,R, 0,1, 1,7,0,7, 0,0));
        tbl.push_back(mk(0, R,R,R,R, 0,0, 1,7,0,7, 0,0));
        tbl.push_back(mk(0, G,R,R,R, 0,0, 1,7,0,7, 0,0));
        tbl.push_back(mk(0, Y,R,R,R, 0,0, 1,7,0,7, 0,1));
        // Reset mid-yellow: re-baseline, next phase change is clean.
        tbl.push_back(mk(1, Y,R,R,R, 0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0, Y,R,R,R, 0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0, R,R,R,R, 0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0, R,R,R,R, 0,0, 0,0,0,0, 0,1));
        tbl.push_back(mk(0, G,R,R,R, 0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0, G,R,R,R, 0,0, 0,0,0,0, 0,1));
        tbl.push_back(mk(0, R,R,R,R, 0,0, 0,0,0,0, 0,0));
        // Green held only one sample before yellow: short green on N.
        tbl.push_back(mk(1, R,R,R,R, 0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0, R,R,R,R, 0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0, G,R,R,R, 0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0, Y,R,R,R, 0,0, 0,0,0,0, 0,1));
        tbl.push_back(mk(0, Y,R,R,R, 0,0, 1,4,0,0, 0,1));
        tbl.push_back(mk(0, Y,R,R,R, 0,0, 1,4,0,0, 0,0));

        foreach (tbl[i])
            step(tbl[i], $sformatf("row%0d", i));

        // While faulted, fault_clr together with a new violation replaces the latched fault.
        step(mk(1, R,R,R,R, 0,0,  0,0,0,0,  0,0), "hs_rst");
        step(mk(0, R,R,R,R, 0,0,  0,0,0,0,  0,0), "hs_first");
        step(mk(0, G,R,R,R, 0,0,  0,0,0,0,  0,0), "hs_base");
        step(mk(0, G,Y,R,R, 3,0,  0,0,0,0,  0,1), "hs_ngreen");
        step(mk(0, R,R,R,R, 11,0, 1,1,0,3,  0,1), "hs_conflict");
        step(mk(0, R,R,R,R, 0,1,  1,3,0,11, 0,1), "hs_clr_new");
        step(mk(0, R,R,R,R, 0,1,  0,0,0,0,  0,0), "hs_clr_only");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
